// File: rtl/program_step_streamer.sv
// Replays a preloaded program onto the processor's switch-data bus, pulsing Step_Clock once per word.
// Optional single-step hold mode is enabled by defining STREAMER_SINGLE_STEP_EN.
module program_step_streamer #(
    parameter  int unsigned DEPTH       = 16,
    parameter  int unsigned SETUP_CYC   = 4,
    parameter  int unsigned PRESS_CYC   = 8,
    parameter  int unsigned RELEASE_CYC = 8,
    localparam int unsigned AW          = $clog2(DEPTH),
    localparam int unsigned DW          = 10,
    localparam int unsigned ICW         = 8
) (
    input  logic            Clock_50MHz,
    input  logic            Reset_n,
    input  logic            Load_Enable,
    input  logic [AW-1:0]   Load_Addr,
    input  logic [DW-1:0]   Load_Data,
    input  logic [AW:0]     Load_Length,
    input  logic            Run,
    input  logic            Done_In,
`ifdef STREAMER_SINGLE_STEP_EN
    input  logic            Step_Req,
    input  logic            Single_Mode,
`endif
    output logic [DW-1:0]   Data_Out,
    output logic            Step_Clock,
    output logic [AW-1:0]   Program_Counter,
    output logic [ICW-1:0]  Instr_Count,
    output logic            Busy,
    output logic            Halted
);

    localparam int unsigned CW = $clog2(SETUP_CYC + PRESS_CYC + RELEASE_CYC + 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SETUP   = 3'd1,
        PRESS   = 3'd2,
        RELEASE = 3'd3,
        HOLD    = 3'd4,
        DONE    = 3'd5
    } state_e;

    state_e         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [AW-1:0]  pc_q, pc_d;
    logic [DW-1:0]  data_q, data_d;
    logic [ICW-1:0] icnt_q, icnt_d;
    logic [AW:0]    len_q, len_d;
    logic           step_clock_q, step_clock_d;
    logic           busy_q, busy_d;
    logic           halted_q, halted_d;
    logic           run_prev_q, run_prev_d;
    logic           done_prev_q, done_prev_d;
    logic [DW-1:0]  mem_q [DEPTH];

    logic run_rise, done_rise, load_ok;
`ifdef STREAMER_SINGLE_STEP_EN
    logic step_prev_q, step_prev_d, step_rise;
    assign step_rise = Step_Req & ~step_prev_q;
`endif

    assign run_rise  = Run & ~run_prev_q;
    assign done_rise = Done_In & ~done_prev_q;
    assign load_ok   = Load_Enable & ~busy_q;

    // Program store: writable whenever no step is in flight; never reset
    always_ff @(posedge Clock_50MHz) begin
        if (load_ok) begin
            mem_q[Load_Addr] <= Load_Data;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pc_d        = pc_q;
        data_d      = data_q;
        icnt_d      = icnt_q;
        len_d       = len_q;
        run_prev_d  = Run;
        done_prev_d = Done_In;
`ifdef STREAMER_SINGLE_STEP_EN
        step_prev_d = Step_Req;
`endif

        if (load_ok && (Load_Addr == AW'(0))) begin
            len_d = (Load_Length > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : Load_Length;
        end

        if ((state_q != IDLE) && done_rise && (icnt_q != {ICW{1'b1}})) begin
            icnt_d = icnt_q + ICW'(1);
        end

        case (state_q)
            IDLE: begin
                if (run_rise) begin
                    if (len_q == (AW+1)'(0)) begin
                        state_d = DONE;
                    end else begin
                        pc_d    = AW'(0);
                        icnt_d  = ICW'(0);
                        data_d  = mem_q[AW'(0)];
                        cnt_d   = CW'(0);
                        state_d = SETUP;
                    end
                end
            end
            SETUP: begin
                if (cnt_q == CW'(SETUP_CYC - 1)) begin
                    cnt_d   = CW'(0);
                    state_d = PRESS;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            PRESS: begin
                if (cnt_q == CW'(PRESS_CYC - 1)) begin
                    cnt_d   = CW'(0);
                    state_d = RELEASE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RELEASE: begin
                if (cnt_q == CW'(RELEASE_CYC - 1)) begin
                    cnt_d = CW'(0);
                    if ((AW+1)'(pc_q) == (len_q - (AW+1)'(1))) begin
                        state_d = DONE;
                    end else if (!Run) begin
                        state_d = IDLE;
`ifdef STREAMER_SINGLE_STEP_EN
                    end else if (Single_Mode) begin
                        state_d = HOLD;
`endif
                    end else begin
                        pc_d    = pc_q + AW'(1);
                        data_d  = mem_q[pc_q + AW'(1)];
                        state_d = SETUP;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
`ifdef STREAMER_SINGLE_STEP_EN
            HOLD: begin
                if (!Run) begin
                    state_d = IDLE;
                end else if (step_rise) begin
                    pc_d    = pc_q + AW'(1);
                    data_d  = mem_q[pc_q + AW'(1)];
                    cnt_d   = CW'(0);
                    state_d = SETUP;
                end
            end
`endif
            DONE: begin
                if (!Run) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Outputs follow the next state so they line up with state_q after the edge
        step_clock_d = (state_d != PRESS);
        busy_d       = (state_d == SETUP) || (state_d == PRESS) ||
                       (state_d == RELEASE) || (state_d == HOLD);
        halted_d     = (state_d == DONE);
    end

    always_ff @(posedge Clock_50MHz) begin
        if (!Reset_n) begin
            state_q      <= IDLE;
            cnt_q        <= CW'(0);
            pc_q         <= AW'(0);
            data_q       <= DW'(0);
            icnt_q       <= ICW'(0);
            len_q        <= (AW+1)'(0);
            step_clock_q <= 1'b1;
            busy_q       <= 1'b0;
            halted_q     <= 1'b0;
            run_prev_q   <= 1'b0;
            done_prev_q  <= 1'b0;
`ifdef STREAMER_SINGLE_STEP_EN
            step_prev_q  <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            pc_q         <= pc_d;
            data_q       <= data_d;
            icnt_q       <= icnt_d;
            len_q        <= len_d;
            step_clock_q <= step_clock_d;
            busy_q       <= busy_d;
            halted_q     <= halted_d;
            run_prev_q   <= run_prev_d;
            done_prev_q  <= done_prev_d;
`ifdef STREAMER_SINGLE_STEP_EN
            step_prev_q  <= step_prev_d;
`endif
        end
    end

    assign Data_Out        = data_q;
    assign Step_Clock      = step_clock_q;
    assign Program_Counter = pc_q;
    assign Instr_Count     = icnt_q;
    assign Busy            = busy_q;
    assign Halted          = halted_q;

endmodule
